// File: rtl/demo_timeline_pkg.sv
// Shared timeline types and ramp constants for the demo sequencer.
package demo_timeline_pkg;

  typedef enum logic [2:0] {
    P_INTRO     = 3'd0,
    P_TEXT_IN   = 3'd1,
    P_HOLD      = 3'd2,
    P_PLANE_IN  = 3'd3,
    P_MAIN      = 3'd4,
    P_TEXT_OUT  = 3'd5,
    P_PLANE_OUT = 3'd6,
    P_END       = 3'd7
  } phase_t;

  localparam logic [11:0] SCROLL_STEP  = 12'd16;
  localparam logic [11:0] SCROLL_HOLD  = 12'd3548;
  localparam logic [11:0] SCROLL_PARK  = 12'd2048;
  // Slide-in start position: one full slide (69 frames * 16 px) short of the hold position.
  localparam logic [11:0] SCROLL_ENTER = SCROLL_HOLD - 12'd1104;

  localparam logic [8:0]  PLANE_HIDDEN = 9'd480;
  localparam logic [8:0]  PLANE_MID    = 9'd240;

  localparam logic [10:0] FRAME_MAX    = 11'd2047;
  localparam logic [5:0]  FADE_FULL    = 6'd63;

endpackage

// File: rtl/demo_sequencer.sv
// Frame-rate timeline controller: phase FSM plus incremental ramps that
// feed the pixel datapath. Everything steps once per frame on frame_tick.
module demo_sequencer
  import demo_timeline_pkg::*;
#(
  parameter int INTRO_LEN      = 32,
  parameter int TEXT_IN_START  = 100,
  parameter int SLIDE_LEN      = 69,
  parameter int PLANE_IN_START = 209,
  parameter int PLANE_LEN      = 240,
  parameter int PLANE_OUT_END  = 1671,
  parameter int SUNRISE_LEN    = 1024
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [7:0]  songpos,
  output logic [10:0] frame,
  output logic [2:0]  phase,
  output logic [11:0] scrollh_anim,
  output logic [8:0]  plane_y_start,
  output logic [10:0] sky_time,
  output logic        sky_active,
  output logic [5:0]  bg_fade
);

  localparam logic [10:0] F_INTRO_END = 11'(INTRO_LEN);
  localparam logic [10:0] F_TEXT_IN   = 11'(TEXT_IN_START);
  localparam logic [10:0] F_HOLD      = 11'(TEXT_IN_START + SLIDE_LEN);
  localparam logic [10:0] F_PLANE_IN  = 11'(PLANE_IN_START);
  localparam logic [10:0] F_MAIN      = 11'(PLANE_IN_START + PLANE_LEN);
  localparam logic [10:0] F_TEXT_OUT  = 11'(PLANE_OUT_END - PLANE_LEN - SLIDE_LEN);
  localparam logic [10:0] F_PLANE_OUT = 11'(PLANE_OUT_END - PLANE_LEN);
  localparam logic [10:0] F_END       = 11'(PLANE_OUT_END);
  localparam logic [10:0] SKY_MAX     = 11'(SUNRISE_LEN);

  phase_t      phase_q;
  logic [10:0] frame_next;
  logic        restart;

  assign phase = phase_q;

  // Saturating next-frame value and the song-loop restart condition.
  always_comb begin
    frame_next = (frame == FRAME_MAX) ? frame : frame + 11'd1;
    restart    = frame_tick && (songpos == 8'd0) && (frame > 11'd8);
  end

  // Phase FSM with its ramps; a restart behaves exactly like rst.
  always_ff @(posedge clk48) begin
    if (rst || restart) begin
      frame         <= 11'd0;
      phase_q       <= P_INTRO;
      scrollh_anim  <= SCROLL_PARK;
      plane_y_start <= PLANE_HIDDEN;
      sky_time      <= 11'd0;
      sky_active    <= 1'b0;
      bg_fade       <= FADE_FULL;
    end else if (frame_tick) begin
      frame   <= frame_next;
      bg_fade <= (frame_next < F_INTRO_END) ? FADE_FULL - {frame_next[4:0], 1'b0} : 6'd0;

      if (sky_active && (sky_time != SKY_MAX)) begin
        sky_time <= sky_time + 11'd1;
      end

      case (phase_q)
        P_INTRO: begin
          if (frame_next == F_TEXT_IN) begin
            phase_q      <= P_TEXT_IN;
            scrollh_anim <= SCROLL_ENTER;
          end
        end
        P_TEXT_IN: begin
          if (frame_next == F_HOLD) begin
            phase_q      <= P_HOLD;
            scrollh_anim <= SCROLL_HOLD;
            sky_active   <= 1'b1;
          end else begin
            scrollh_anim <= scrollh_anim + SCROLL_STEP;
          end
        end
        P_HOLD: begin
          if (frame_next == F_PLANE_IN) begin
            phase_q <= P_PLANE_IN;
          end
        end
        P_PLANE_IN: begin
          if (frame_next == F_MAIN) begin
            phase_q       <= P_MAIN;
            plane_y_start <= PLANE_MID;
          end else begin
            plane_y_start <= plane_y_start - 9'd1;
          end
        end
        P_MAIN: begin
          if (frame_next == F_TEXT_OUT) begin
            phase_q <= P_TEXT_OUT;
          end
        end
        P_TEXT_OUT: begin
          if (frame_next == F_PLANE_OUT) begin
            phase_q      <= P_PLANE_OUT;
            scrollh_anim <= SCROLL_PARK;
          end else begin
            scrollh_anim <= scrollh_anim + SCROLL_STEP;
          end
        end
        P_PLANE_OUT: begin
          if (frame_next == F_END) begin
            phase_q       <= P_END;
            plane_y_start <= 9'd0;
          end else begin
            plane_y_start <= plane_y_start - 9'd1;
          end
        end
        P_END: begin
          phase_q <= P_END;
        end
        default: begin
          phase_q <= P_END;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed scoreboard bench for demo_sequencer: stimulus pushes hand-computed
// snapshots, a negedge monitor pops and compares them against the outputs.
`timescale 1ns/1ps
module tb_demo_sequencer;
  import demo_timeline_pkg::*;

  logic        clk48;
  logic        rst;
  logic        frame_tick;
  logic [7:0]  songpos;
  logic [10:0] frame;
  logic [2:0]  phase;
  logic [11:0] scrollh_anim;
  logic [8:0]  plane_y_start;
  logic [10:0] sky_time;
  logic        sky_active;
  logic [5:0]  bg_fade;

  typedef struct {
    string name;
    int    fr;
    int    ph;
    int    sc;
    int    pl;
    int    st;
    int    sa;
    int    bg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cur_frame = 0;

  demo_sequencer dut (
    .clk48         (clk48),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .songpos       (songpos),
    .frame         (frame),
    .phase         (phase),
    .scrollh_anim  (scrollh_anim),
    .plane_y_start (plane_y_start),
    .sky_time      (sky_time),
    .sky_active    (sky_active),
    .bg_fade       (bg_fade)
  );

  // Free-running pixel clock.
  initial clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  task automatic compareField(input string tag, input string field, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
      end
    end
  endtask

  // Monitor: drain every pending expectation at the falling edge, away from updates.
  always @(negedge clk48) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compareField(mon_e.name, "frame",         int'(frame),         mon_e.fr);
      compareField(mon_e.name, "phase",         int'(phase),         mon_e.ph);
      compareField(mon_e.name, "scrollh_anim",  int'(scrollh_anim),  mon_e.sc);
      compareField(mon_e.name, "plane_y_start", int'(plane_y_start), mon_e.pl);
      compareField(mon_e.name, "sky_time",      int'(sky_time),      mon_e.st);
      compareField(mon_e.name, "sky_active",    int'(sky_active),    mon_e.sa);
      compareField(mon_e.name, "bg_fade",       int'(bg_fade),       mon_e.bg);
    end
  end

  task automatic checkOutput(input string name, input int fr, input int ph, input int sc,
                             input int pl, input int st, input int sa, input int bg);
    exp_t e;
    e.name = name; e.fr = fr; e.ph = ph; e.sc = sc;
    e.pl = pl; e.st = st; e.sa = sa; e.bg = bg;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] sp);
    @(posedge clk48); #1;
    songpos    = sp;
    frame_tick = 1'b1;
    @(posedge clk48); #1;
    frame_tick = 1'b0;
    if (sp == 8'd0 && cur_frame > 8) cur_frame = 0;
    else if (cur_frame < 2047)       cur_frame = cur_frame + 1;
  endtask

  task automatic runTo(input int target);
    while (cur_frame < target) applyStimulus(8'd7);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst = 1'b1; frame_tick = 1'b0; songpos = 8'd7;
    repeat (3) @(posedge clk48);
    #1 rst = 1'b0;
    checkOutput("reset", 0, int'(P_INTRO), 2048, 480, 0, 0, 63);

    repeat (3) applyStimulus(8'd7);
    checkOutput("frame3", 3, int'(P_INTRO), 2048, 480, 0, 0, 57);

    @(posedge clk48); #1 rst = 1'b1; frame_tick = 1'b1;
    @(posedge clk48); #1 frame_tick = 1'b0;
    checkOutput("rst_cycle1", 0, int'(P_INTRO), 2048, 480, 0, 0, 63);
    @(posedge clk48); #1 rst = 1'b0;
    cur_frame = 0;
    checkOutput("rst_release", 0, int'(P_INTRO), 2048, 480, 0, 0, 63);

    runTo(5);
    applyStimulus(8'd0);
    checkOutput("sp0_at5", 6, int'(P_INTRO), 2048, 480, 0, 0, 51);
    runTo(8);
    applyStimulus(8'd0);
    checkOutput("sp0_at8", 9, int'(P_INTRO), 2048, 480, 0, 0, 45);
    applyStimulus(8'd0);
    checkOutput("sp0_at9", 0, int'(P_INTRO), 2048, 480, 0, 0, 63);

    runTo(31);  checkOutput("f31",  31,  int'(P_INTRO),    2048, 480, 0,  0, 1);
    runTo(32);  checkOutput("f32",  32,  int'(P_INTRO),    2048, 480, 0,  0, 0);
    runTo(99);  checkOutput("f99",  99,  int'(P_INTRO),    2048, 480, 0,  0, 0);
    runTo(100); checkOutput("f100", 100, int'(P_TEXT_IN),  2444, 480, 0,  0, 0);
    runTo(168); checkOutput("f168", 168, int'(P_TEXT_IN),  3532, 480, 0,  0, 0);
    runTo(169); checkOutput("f169", 169, int'(P_HOLD),     3548, 480, 0,  1, 0);
    runTo(170); checkOutput("f170", 170, int'(P_HOLD),     3548, 480, 1,  1, 0);
    runTo(209); checkOutput("f209", 209, int'(P_PLANE_IN), 3548, 480, 40, 1, 0);
    runTo(210); checkOutput("f210", 210, int'(P_PLANE_IN), 3548, 479, 41, 1, 0);
    runTo(448); checkOutput("f448", 448, int'(P_PLANE_IN), 3548, 241, 279, 1, 0);
    runTo(449); checkOutput("f449", 449, int'(P_MAIN),     3548, 240, 280, 1, 0);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk48); #1;
      checkOutput("hold", 449, int'(P_MAIN), 3548, 240, 280, 1, 0);
    end

    runTo(500); checkOutput("f500", 500, int'(P_MAIN), 3548, 240, 331, 1, 0);
    applyStimulus(8'd0);
    checkOutput("restart500", 0, int'(P_INTRO), 2048, 480, 0, 0, 63);

    runTo(1192); checkOutput("f1192", 1192, int'(P_MAIN),      3548, 240, 1023, 1, 0);
    runTo(1193); checkOutput("f1193", 1193, int'(P_MAIN),      3548, 240, 1024, 1, 0);
    runTo(1361); checkOutput("f1361", 1361, int'(P_MAIN),      3548, 240, 1024, 1, 0);
    runTo(1362); checkOutput("f1362", 1362, int'(P_TEXT_OUT),  3548, 240, 1024, 1, 0);
    runTo(1363); checkOutput("f1363", 1363, int'(P_TEXT_OUT),  3564, 240, 1024, 1, 0);
    runTo(1431); checkOutput("f1431", 1431, int'(P_PLANE_OUT), 2048, 240, 1024, 1, 0);
    runTo(1432); checkOutput("f1432", 1432, int'(P_PLANE_OUT), 2048, 239, 1024, 1, 0);
    runTo(1670); checkOutput("f1670", 1670, int'(P_PLANE_OUT), 2048, 1,   1024, 1, 0);
    runTo(1671); checkOutput("f1671", 1671, int'(P_END),       2048, 0,   1024, 1, 0);
    runTo(2046); checkOutput("f2046", 2046, int'(P_END),       2048, 0,   1024, 1, 0);
    runTo(2047); checkOutput("f2047", 2047, int'(P_END),       2048, 0,   1024, 1, 0);
    repeat (53) applyStimulus(8'd7);
    checkOutput("saturated", 2047, int'(P_END), 2048, 0, 1024, 1, 0);

    repeat (3) @(posedge clk48);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
